// File: rtl/ex_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the EX-stage hazard controller.
// The master side belongs to the pipeline, which supplies the instruction fields and consumes the stall and forwarding controls.
interface ex_hazard_ctrl_if #(
  parameter int INSTR_W = 19
);
  logic [INSTR_W-1:0] PR1_instruction;
  logic               ID_uses_rs1;
  logic               ID_uses_rs2;
  logic [INSTR_W-1:0] PR2_instruction;
  logic               PR2_MEM_read;
  logic               PR2_RF_write_en;
  logic               PR2_uses_rs1;
  logic               PR2_uses_rs2;
  logic               stall_PR1;
  logic               stall_PR2;
  logic               bubble_PR2;
  logic               hold_EX;
  logic               fwd_sel_a;
  logic               fwd_sel_b;
  logic               busy;

  modport master (
    output PR1_instruction, ID_uses_rs1, ID_uses_rs2,
    output PR2_instruction, PR2_MEM_read, PR2_RF_write_en, PR2_uses_rs1, PR2_uses_rs2,
    input  stall_PR1, stall_PR2, bubble_PR2, hold_EX, fwd_sel_a, fwd_sel_b, busy
  );

  modport slave (
    input  PR1_instruction, ID_uses_rs1, ID_uses_rs2,
    input  PR2_instruction, PR2_MEM_read, PR2_RF_write_en, PR2_uses_rs1, PR2_uses_rs2,
    output stall_PR1, stall_PR2, bubble_PR2, hold_EX, fwd_sel_a, fwd_sel_b, busy
  );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard control: load-use stalls, multi-cycle load freezes and WB->EX operand forwarding.
// Tracks the WB destination locally so the forwarding compare needs no extra pipeline fields.
module ex_hazard_ctrl #(
  parameter int INSTR_W        = 19,
  parameter int REG_AW         = 3,
  parameter int RD_LSB         = 11,
  parameter int RS1_LSB        = 8,
  parameter int RS2_LSB        = 5,
  parameter int MEM_RD_LATENCY = 1
) (
  input logic              clk,
  input logic              rst,
  ex_hazard_ctrl_if.slave  hz
);

  typedef enum logic {RUN = 1'b0, LOAD_WAIT = 1'b1} state_t;

  localparam logic [3:0] CNT_INIT = (MEM_RD_LATENCY > 1) ? 4'(MEM_RD_LATENCY - 2) : 4'd0;
  localparam bit         MULTI_LD = (MEM_RD_LATENCY > 1);

  function automatic logic [REG_AW-1:0] fld(input logic [INSTR_W-1:0] instr, input int lsb);
    return instr[lsb +: REG_AW];
  endfunction

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [REG_AW-1:0] wb_rd_p1;
  logic              wb_we_p1;
  logic              load_use, freeze, final_ld;
  logic              unused_bits;

  // Opcode and immediate bits are of no interest to the hazard logic.
  assign unused_bits = ^{hz.PR1_instruction, hz.PR2_instruction};

  assign load_use = hz.PR2_MEM_read & hz.PR2_RF_write_en &
                    ((hz.ID_uses_rs1 & (fld(hz.PR1_instruction, RS1_LSB) == fld(hz.PR2_instruction, RD_LSB))) |
                     (hz.ID_uses_rs2 & (fld(hz.PR1_instruction, RS2_LSB) == fld(hz.PR2_instruction, RD_LSB))));

  // Freeze covers every load cycle except the last; the last one only stalls on a dependency.
  assign freeze   = ((state_q == RUN) & hz.PR2_MEM_read & MULTI_LD) |
                    ((state_q == LOAD_WAIT) & (cnt_q != 4'd0));
  assign final_ld = ((state_q == RUN) & hz.PR2_MEM_read & ~MULTI_LD) |
                    ((state_q == LOAD_WAIT) & (cnt_q == 4'd0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (hz.PR2_MEM_read && MULTI_LD) begin
          state_d = LOAD_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      LOAD_WAIT: begin
        if (cnt_q != 4'd0) cnt_d   = cnt_q - 4'd1;
        else               state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    hz.stall_PR1  = ~rst & (freeze | (final_ld & load_use));
    hz.stall_PR2  = ~rst & freeze;
    hz.bubble_PR2 = ~rst & final_ld & load_use & ~freeze;
    hz.hold_EX    = ~rst & freeze;
    hz.fwd_sel_a  = ~rst & ~freeze & wb_we_p1 & hz.PR2_uses_rs1 &
                    (fld(hz.PR2_instruction, RS1_LSB) == wb_rd_p1);
    hz.fwd_sel_b  = ~rst & ~freeze & wb_we_p1 & hz.PR2_uses_rs2 &
                    (fld(hz.PR2_instruction, RS2_LSB) == wb_rd_p1);
    hz.busy       = (state_q == LOAD_WAIT);
  end

  // EX -> WB boundary: shadow of the destination the WB stage is writing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_rd_p1 <= '0;
      wb_we_p1 <= 1'b0;
    end else if (!freeze) begin
      wb_rd_p1 <= fld(hz.PR2_instruction, RD_LSB);
      wb_we_p1 <= hz.PR2_RF_write_en;
    end
  end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl: four instances with read latencies 1..4 share one stimulus stream.
// Expected output vectors {stall_PR1,stall_PR2,bubble_PR2,hold_EX,fwd_sel_a,fwd_sel_b,busy} go through a scoreboard queue.
module tb_ex_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [18:0] pr1, pr2;
  logic        id1, id2, mr, we, u1, u2;
  logic [6:0]  obs [4];

  ex_hazard_ctrl_if #(.INSTR_W(19)) bus [4] ();

  for (genvar g = 0; g < 4; g++) begin : g_dut
    assign bus[g].PR1_instruction = pr1;
    assign bus[g].ID_uses_rs1     = id1;
    assign bus[g].ID_uses_rs2     = id2;
    assign bus[g].PR2_instruction = pr2;
    assign bus[g].PR2_MEM_read    = mr;
    assign bus[g].PR2_RF_write_en = we;
    assign bus[g].PR2_uses_rs1    = u1;
    assign bus[g].PR2_uses_rs2    = u2;
    assign obs[g] = {bus[g].stall_PR1, bus[g].stall_PR2, bus[g].bubble_PR2, bus[g].hold_EX,
                     bus[g].fwd_sel_a, bus[g].fwd_sel_b, bus[g].busy};

    ex_hazard_ctrl #(
      .INSTR_W(19), .REG_AW(3), .RD_LSB(11), .RS1_LSB(8), .RS2_LSB(5),
      .MEM_RD_LATENCY(g + 1)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .hz (bus[g])
    );
  end

  typedef struct {
    string      tag;
    int         inst;
    logic [6:0] exp;
  } exp_t;

  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [18:0] mk(input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2);
    return {5'b10110, rd, rs1, rs2, 5'b00101};
  endfunction

  task automatic drive(input logic [18:0] p1, input logic i1, input logic i2,
                       input logic [18:0] p2, input logic m, input logic w,
                       input logic a, input logic b);
    pr1 = p1; id1 = i1; id2 = i2;
    pr2 = p2; mr = m; we = w; u1 = a; u2 = b;
  endtask

  task automatic expect_out(input string tag, input int inst, input logic [6:0] e);
    exp_t ent;
    ent.tag = tag; ent.inst = inst; ent.exp = e;
    sb.push_back(ent);
  endtask

  task automatic expect_all(input string tag, input logic [6:0] e);
    for (int i = 0; i < 4; i++) expect_out(tag, i, e);
  endtask

  task automatic check_pending();
    exp_t ent;
    while (sb.size() > 0) begin
      ent = sb.pop_front();
      checks++;
      assert (obs[ent.inst] === ent.exp)
      else begin
        errors++;
        $error("FAIL %s lat%0d observed=%b expected=%b", ent.tag, ent.inst + 1, obs[ent.inst], ent.exp);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_pending();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive('0, 0, 0, '0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    expect_all("in_reset", 7'b0000000);
    check_pending();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive('0, 0, 0, '0, 0, 0, 0, 0);
    #1;
    expect_all("reset_state", 7'b0000000);
    check_pending();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // Load-use with single-cycle read latency, then no-false-stall and forwarding.
    drive(mk(0, 3, 1), 1, 0, mk(3, 0, 0), 1, 1, 0, 0);
    expect_out("lu_lat1", 0, 7'b1010000);
    tick();
    drive(mk(0, 3, 1), 1, 0, '0, 0, 0, 0, 0);
    expect_out("lu_lat1_after", 0, 7'b0000000);
    tick();
    drive(mk(0, 5, 3), 1, 0, mk(3, 0, 0), 1, 1, 0, 0);
    expect_out("no_false_stall", 0, 7'b0000000);
    tick();
    drive('0, 0, 0, mk(1, 3, 3), 0, 1, 1, 0);
    expect_out("fwd_after_load", 0, 7'b0000100);
    tick();

    // Four-cycle load without dependency.
    do_reset();
    drive(mk(0, 7, 7), 1, 0, mk(2, 0, 0), 1, 1, 0, 0);
    expect_out("lat4_c1", 3, 7'b1101000);
    tick();
    expect_out("lat4_c2", 3, 7'b1101001);
    tick();
    expect_out("lat4_c3", 3, 7'b1101001);
    tick();
    expect_out("lat4_c4", 3, 7'b0000001);
    tick();
    drive('0, 0, 0, mk(5, 2, 4), 0, 1, 1, 1);
    expect_out("lat4_wb_rd", 3, 7'b0000100);
    tick();

    // Reset asserted mid LOAD_WAIT, with a forwardable WB value pending.
    do_reset();
    drive('0, 0, 0, mk(6, 0, 0), 0, 1, 0, 0);
    expect_out("lat3_pre", 2, 7'b0000000);
    tick();
    drive('0, 0, 0, mk(4, 0, 0), 1, 1, 0, 0);
    expect_out("lat3_c1", 2, 7'b1101000);
    tick();
    expect_out("lat3_c2", 2, 7'b1101001);
    @(negedge clk);
    check_pending();
    #2;
    rst = 1'b1;
    drive('0, 0, 0, '0, 0, 0, 0, 0);
    #1;
    expect_out("lat3_mid_reset", 2, 7'b0000000);
    check_pending();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive('0, 0, 0, mk(0, 6, 0), 0, 0, 1, 0);
    expect_out("lat3_post_reset", 2, 7'b0000000);
    tick();

    // Two-cycle load with load-use and a simultaneous forwarding match.
    do_reset();
    drive('0, 0, 0, mk(1, 0, 0), 0, 1, 0, 0);
    expect_out("lat2_pre", 1, 7'b0000000);
    tick();
    drive(mk(0, 0, 3), 0, 1, mk(3, 1, 0), 1, 1, 1, 0);
    expect_out("lat2_freeze", 1, 7'b1101000);
    tick();
    expect_out("lat2_final_lu", 1, 7'b1010101);
    tick();
    drive(mk(0, 0, 3), 0, 1, '0, 0, 0, 0, 0);
    expect_out("lat2_after", 1, 7'b0000000);
    tick();

    // Forwarding on both operands, and its absence when the producer does not write.
    do_reset();
    drive('0, 0, 0, mk(6, 0, 0), 0, 1, 0, 0);
    expect_all("fwd_prod", 7'b0000000);
    tick();
    drive('0, 0, 0, mk(0, 6, 6), 0, 0, 1, 1);
    expect_all("fwd_both", 7'b0000110);
    tick();
    drive('0, 0, 0, mk(6, 0, 0), 0, 0, 0, 0);
    expect_all("nofwd_prod", 7'b0000000);
    tick();
    drive('0, 0, 0, mk(0, 6, 6), 0, 0, 1, 1);
    expect_all("nofwd_cons", 7'b0000000);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
